// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage in front of the single-cycle core. It fetches the
// 32-bit word at the core's pc over a request/response memory handshake. A
// one-entry buffer (tag + data + error flag) holds the last returned word, so
// a pc that is already buffered is never fetched again. While the word for
// the current pc is unavailable, a NOP bubble is presented and instr_valid is
// low, which lets the stall logic freeze architectural state.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   pc           fetch address from the core
//   instruction  word to the core (NOP_INSN when not valid)
//   instr_valid  instruction is the memory word at the current pc
//   fault        pc is misaligned, or its buffered fetch returned an error
//   mem_req      request valid (high exactly while in REQ)
//   mem_addr     request address, constant from REQ entry until WAIT exit
//   mem_ready    memory accepts the request this cycle
//   mem_rvalid   response valid (sampled only in WAIT)
//   mem_rdata    response word
//   mem_rerr     response is an access error, qualified by mem_rvalid
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int          ADDR_WIDTH = 64,
    parameter logic [31:0] NOP_INSN   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [31:0]           instruction,
    output logic                  instr_valid,
    output logic                  fault,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rerr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetchStateT;

    fetchStateT            state;
    logic                  bufValid;
    logic                  bufErr;
    logic [ADDR_WIDTH-1:0] bufTag;
    logic [31:0]           bufData;
    logic [ADDR_WIDTH-1:0] reqAddr;

    logic hit;
    logic misaligned;

    // Hits are purely combinational, so a buffered pc costs zero cycles.
    assign hit        = bufValid && (bufTag == pc);
    assign misaligned = (pc[1:0] != 2'b00);

    assign instr_valid = hit && !bufErr && !misaligned;
    assign instruction = instr_valid ? bufData : NOP_INSN;
    assign fault       = misaligned || (hit && bufErr);

    // Both request outputs come straight from registers: nothing on the
    // memory side can reach them combinationally.
    assign mem_req  = (state == REQ);
    assign mem_addr = reqAddr;

    // NOTE: every register here is assigned with <= so all of them see the
    // pre-edge values of each other; blocking assignments would make the
    // result depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the buffer is a handful of flops, not a RAM, so clearing
            // tag and data as well as the valid bit costs nothing and keeps
            // the post-reset state fully deterministic.
            state    <= IDLE;
            bufValid <= 1'b0;
            bufErr   <= 1'b0;
            bufTag   <= '0;
            bufData  <= '0;
            reqAddr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Misaligned pcs never go to memory; fault stays up
                    // combinationally until the core moves pc.
                    if (!hit && !misaligned) begin
                        reqAddr <= pc;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    // A request is never withdrawn, even if pc moves.
                    if (mem_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // The response is tagged with the address that was
                    // requested, not the current pc: a redirected pc then
                    // simply misses in IDLE and triggers a fresh request.
                    if (mem_rvalid) begin
                        bufValid <= 1'b1;
                        bufTag   <= reqAddr;
                        bufData  <= mem_rdata;
                        bufErr   <= mem_rerr;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
